// File: rtl/sr_debug_dumper_pkg.sv
// Shared definitions for the debug register dumper.
//  - dbg_state_e : dumper FSM states
//  - ASCII base constants used by the nibble-to-hex converter
//  - nibble_at() : selects nibble idx of a 32-bit word, idx 0 = most significant
package sr_debug_dumper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SEND    = 3'd2,
        ST_SEP     = 3'd3,
        ST_DONE    = 3'd4
    } dbg_state_e;

    localparam logic [7:0] ASCII_ZERO    = 8'h30;  // '0'
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;  // 'A'
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;  // 'a'
    localparam logic [7:0] HEX_LETTER_OFFSET = 8'd10;

    // Index of the last (least significant) nibble of a 32-bit word.
    localparam logic [2:0] NIB_LAST = 3'd7;

    // Nibble 0 is bits [31:28], nibble 7 is bits [3:0].
    function automatic logic [3:0] nibble_at(input logic [31:0] word, input logic [2:0] idx);
        logic [4:0] lsb;
        lsb = {(NIB_LAST - idx), 2'b00};
        return word[lsb +: 4];
    endfunction

endpackage

// File: rtl/sr_debug_dumper_if.sv
// Debug-port and byte-stream bundle of the debug register dumper.
//  master : the dumper (drives regAddr and the tx byte stream, status)
//  slave  : the surroundings (CPU debug port data, start request, tx sink ready)
//  start    request a dump
//  regAddr  debug register address
//  regData  debug register data, combinational from regAddr
//  tx_data  ASCII byte, tx_valid qualifies it, tx_ready accepts it
//  busy     dumper not idle
//  done     one-cycle completion pulse
interface sr_debug_dumper_if;

    logic        start;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    modport master (
        input  start, regData, tx_ready,
        output regAddr, tx_data, tx_valid, busy, done
    );

    modport slave (
        output start, regData, tx_ready,
        input  regAddr, tx_data, tx_valid, busy, done
    );

endinterface

// File: rtl/sr_debug_dumper_hex_char.sv
// Combinational nibble to ASCII hex character converter.
//  i_nibble  in  4  value 0..15
//  i_upper   in  1  1: letters 'A'-'F', 0: letters 'a'-'f'
//  o_char    out 8  ASCII character
module sr_debug_dumper_hex_char
    import sr_debug_dumper_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_upper,
    output logic [7:0] o_char
);

    // Digits map onto '0'..'9'; 10..15 map onto the selected letter case.
    always_comb begin
        o_char = ASCII_ZERO;
        if (i_nibble < 4'd10) begin
            o_char = ASCII_ZERO + {4'd0, i_nibble};
        end else if (i_upper) begin
            o_char = ASCII_UPPER_A + {4'd0, i_nibble} - HEX_LETTER_OFFSET;
        end else begin
            o_char = ASCII_LOWER_A + {4'd0, i_nibble} - HEX_LETTER_OFFSET;
        end
    end

endmodule

// File: rtl/sr_debug_dumper.sv
// Debug register dumper. On start it walks regAddr from REG_FIRST to REG_LAST,
// samples each register and streams it as 8 ASCII hex characters (MS nibble
// first) followed by SEP_CHAR over a valid/ready byte stream.
//  clk    in  1  clock, rising edge
//  rst_n  in  1  asynchronous active-low reset
//  bus    master modport of sr_debug_dumper_if (start, regAddr, regData,
//         tx_data, tx_valid, tx_ready, busy, done)
// The values are sampled one register at a time while the CPU keeps running,
// so a dump is not a coherent snapshot.
module sr_debug_dumper
    import sr_debug_dumper_pkg::*;
#(
    parameter int unsigned REG_FIRST = 0,
    parameter int unsigned REG_LAST  = 31,
    parameter logic [7:0]  SEP_CHAR  = 8'h0A,
    parameter int unsigned HEX_UPPER = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_debug_dumper_if.master  bus
);

    localparam logic [4:0] ADDR_FIRST = REG_FIRST[4:0];
    localparam logic [4:0] ADDR_LAST  = REG_LAST[4:0];
    localparam logic       UPPER_HEX  = (HEX_UPPER != 32'd0);

    dbg_state_e  r_state;
    logic [4:0]  r_addr;
    logic [31:0] r_data;
    logic [2:0]  r_nib;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_busy;
    logic        r_done;

    logic [3:0]  w_nibble;
    logic [7:0]  w_hex;

    // Nibble whose character is loaded next: the MS nibble of the word being
    // captured, or the nibble after the one currently on the stream.
    always_comb begin
        w_nibble = 4'h0;
        if (r_state == ST_CAPTURE) begin
            w_nibble = nibble_at(bus.regData, 3'd0);
        end else begin
            w_nibble = nibble_at(r_data, r_nib + 3'd1);
        end
    end

    sr_debug_dumper_hex_char u_hex (
        .i_nibble (w_nibble),
        .i_upper  (UPPER_HEX),
        .o_char   (w_hex)
    );

    // Dump FSM; tx_data is loaded one step ahead so every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= 5'd0;
            r_data     <= 32'd0;
            r_nib      <= 3'd0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_addr  <= ADDR_FIRST;
                        r_busy  <= 1'b1;
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    // regAddr has been stable for the whole previous cycle.
                    r_data     <= bus.regData;
                    r_nib      <= 3'd0;
                    r_tx_data  <= w_hex;
                    r_tx_valid <= 1'b1;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (bus.tx_ready) begin
                        if (r_nib == NIB_LAST) begin
                            r_tx_data <= SEP_CHAR;
                            r_state   <= ST_SEP;
                        end else begin
                            r_nib     <= r_nib + 3'd1;
                            r_tx_data <= w_hex;
                        end
                    end
                end
                ST_SEP: begin
                    if (bus.tx_ready) begin
                        r_tx_valid <= 1'b0;
                        if (r_addr == ADDR_LAST) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_addr  <= r_addr + 5'd1;
                            r_state <= ST_CAPTURE;
                        end
                    end
                end
                ST_DONE: begin
                    // regAddr keeps REG_LAST until the next start.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.regAddr  = r_addr;
    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = r_tx_valid;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_sr_debug_dumper.sv
// Self-checking bench for sr_debug_dumper. Four dumpers with different
// parameter sets share clock, reset, start and tx_ready. Each one is checked
// every cycle against a queue of expected cycles built from the register file
// contents when a dump begins, plus literal expectations for known dumps.
module tb_sr_debug_dumper;

    localparam int N = 4;
    localparam int         P_FIRST [N] = '{5, 0, 0, 2};
    localparam int         P_LAST  [N] = '{5, 31, 31, 9};
    localparam int         P_UPPER [N] = '{1, 1, 0, 0};
    localparam logic [7:0] P_SEP   [N] = '{8'h0A, 8'h0A, 8'h0A, 8'h2C};

    typedef enum logic [1:0] {K_GAP, K_BYTE, K_DONE} kind_e;
    typedef struct packed {
        kind_e      kind;
        logic [7:0] b;
        logic [4:0] addr;
        logic [3:0] nib;
    } tok_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_s;
    logic        tx_ready_s;
    logic [31:0] mem [32];

    tok_t        exp_q     [N][$];
    logic [7:0]  log_q     [N][$];
    logic [4:0]  idle_addr [N];
    int          done_cnt  [N];
    int          n_vec;
    int          n_err;
    int          cyc;
    int          first_valid_cyc;
    int          start_cyc;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sr_debug_dumper_if u_if ();
        assign u_if.start    = start_s;
        assign u_if.tx_ready = tx_ready_s;
        assign u_if.regData  = mem[u_if.regAddr];
        sr_debug_dumper #(
            .REG_FIRST (P_FIRST[g]),
            .REG_LAST  (P_LAST[g]),
            .SEP_CHAR  (P_SEP[g]),
            .HEX_UPPER (P_UPPER[g])
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (u_if.master)
        );
    end

    function automatic logic [7:0] hexc(input logic [3:0] n, input int up);
        if (n < 4'd10) return 8'd48 + {4'd0, n};
        else if (up != 0) return 8'd55 + {4'd0, n};
        else return 8'd87 + {4'd0, n};
    endfunction

    function automatic bit any_busy();
        for (int k = 0; k < N; k++) if (exp_q[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Expected cycles of a whole dump: capture gap, 8 hex chars, separator per register, then done.
    task automatic push_dump(input int k);
        for (int r = P_FIRST[k]; r <= P_LAST[k]; r++) begin
            exp_q[k].push_back(tok_t'{K_GAP, 8'h00, 5'(r), 4'd0});
            for (int n = 0; n < 8; n++)
                exp_q[k].push_back(tok_t'{K_BYTE, hexc(4'((mem[r] >> (28 - 4 * n)) & 32'hF), P_UPPER[k]),
                                          5'(r), 4'(n)});
            exp_q[k].push_back(tok_t'{K_BYTE, P_SEP[k], 5'(r), 4'd8});
        end
        exp_q[k].push_back(tok_t'{K_DONE, 8'h00, 5'(P_LAST[k]), 4'd0});
    endtask

    task automatic chk(input int k, input logic [7:0] td, input logic tv, input logic bs,
                       input logic dn, input logic [4:0] ra);
        tok_t       t;
        logic       e_v, e_b, e_d;
        logic [4:0] e_a;
        logic [7:0] e_td;
        bit         td_care;
        e_v = 1'b0; e_b = 1'b0; e_d = 1'b0; e_a = 5'd0; e_td = 8'h00; td_care = 1'b0;
        n_vec++;
        if (dn === 1'b1) done_cnt[k]++;
        if (k == 0 && tv === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (!rst_n) begin
            exp_q[k].delete();
            idle_addr[k] = 5'd0;
        end else if (exp_q[k].size() == 0) begin
            e_a = idle_addr[k];
            if (start_s) push_dump(k);
        end else begin
            t = exp_q[k].pop_front();
            e_b = 1'b1;
            e_a = t.addr;
            case (t.kind)
                K_BYTE: begin
                    e_v = 1'b1; e_td = t.b; td_care = 1'b1;
                    if (tx_ready_s) log_q[k].push_back(td);
                    else exp_q[k].push_front(t);
                end
                K_DONE: begin
                    e_d = 1'b1;
                    idle_addr[k] = t.addr;
                end
                default: ;
            endcase
        end
        if (tv !== e_v || bs !== e_b || dn !== e_d || ra !== e_a || (td_care && td !== e_td)) begin
            n_err++;
            $display("FAIL cycle%0d inst%0d: got valid=%b data=%h busy=%b done=%b addr=%0d, want valid=%b data=%h(care=%0d) busy=%b done=%b addr=%0d",
                     cyc, k, tv, td, bs, dn, ra, e_v, e_td, td_care, e_b, e_d, e_a);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        chk(0, g_dut[0].u_if.tx_data, g_dut[0].u_if.tx_valid, g_dut[0].u_if.busy, g_dut[0].u_if.done, g_dut[0].u_if.regAddr);
        chk(1, g_dut[1].u_if.tx_data, g_dut[1].u_if.tx_valid, g_dut[1].u_if.busy, g_dut[1].u_if.done, g_dut[1].u_if.regAddr);
        chk(2, g_dut[2].u_if.tx_data, g_dut[2].u_if.tx_valid, g_dut[2].u_if.busy, g_dut[2].u_if.done, g_dut[2].u_if.regAddr);
        chk(3, g_dut[3].u_if.tx_data, g_dut[3].u_if.tx_valid, g_dut[3].u_if.busy, g_dut[3].u_if.done, g_dut[3].u_if.regAddr);
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string nm, input int act, input int want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, want, want);
        end
    endtask

    // Outputs right after reset assertion, before any clock edge.
    task automatic chk_rst_now(input int k, input logic tv, input logic bs, input logic dn, input logic [4:0] ra);
        n_vec++;
        if (tv !== 1'b0 || bs !== 1'b0 || dn !== 1'b0 || ra !== 5'd0) begin
            n_err++;
            $display("FAIL async_reset inst%0d: got valid=%b busy=%b done=%b addr=%0d, want 0 0 0 0", k, tv, bs, dn, ra);
        end
    endtask

    task automatic all_rst_now();
        chk_rst_now(0, g_dut[0].u_if.tx_valid, g_dut[0].u_if.busy, g_dut[0].u_if.done, g_dut[0].u_if.regAddr);
        chk_rst_now(1, g_dut[1].u_if.tx_valid, g_dut[1].u_if.busy, g_dut[1].u_if.done, g_dut[1].u_if.regAddr);
        chk_rst_now(2, g_dut[2].u_if.tx_valid, g_dut[2].u_if.busy, g_dut[2].u_if.done, g_dut[2].u_if.regAddr);
        chk_rst_now(3, g_dut[3].u_if.tx_valid, g_dut[3].u_if.busy, g_dut[3].u_if.done, g_dut[3].u_if.regAddr);
    endtask

    task automatic wait_idle(input int budget, input bit rnd_ready);
        int i;
        i = 0;
        while (any_busy() && i < budget) begin
            if (rnd_ready) tx_ready_s = 1'($urandom_range(0, 1));
            step();
            i++;
        end
        tx_ready_s = 1'b1;
        if (any_busy()) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: dump still running after %0d cycles", budget);
            for (int k = 0; k < N; k++) exp_q[k].delete();
        end
        step();
    endtask

    task automatic pulse_start();
        start_s = 1'b1;
        step();
        start_s = 1'b0;
    endtask

    task automatic clear_logs();
        for (int k = 0; k < N; k++) begin
            log_q[k].delete();
            done_cnt[k] = 0;
        end
    endtask

    task automatic chk_tail(input int k, input string s, input string nm);
        int sz;
        sz = log_q[k].size();
        pin({nm, "_count"}, sz, 288);
        if (sz >= 9)
            for (int i = 0; i < 9; i++) pin(nm, int'(log_q[k][sz - 9 + i]), int'(s[i]));
    endtask

    task automatic chk_dead_beef(input string nm);
        logic [7:0] want [9];
        want = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0A};
        pin({nm, "_count"}, log_q[0].size(), 9);
        if (log_q[0].size() == 9)
            for (int i = 0; i < 9; i++) pin(nm, int'(log_q[0][i]), int'(want[i]));
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; first_valid_cyc = -1; start_cyc = 0;
        for (int k = 0; k < N; k++) begin
            idle_addr[k] = 5'd0;
            done_cnt[k]  = 0;
        end
        for (int a = 0; a < 32; a++) mem[a] = $urandom;
        mem[5] = 32'hDEADBEEF;
        rst_n = 1'b1; start_s = 1'b0; tx_ready_s = 1'b1;

        // Reset held with start high: nothing may leave any dumper.
        #1;
        rst_n = 1'b0;
        start_s = 1'b1;
        #1;
        all_rst_now();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step();
        start_s = 1'b0;
        rst_n = 1'b1;
        step();
        step();
        for (int k = 0; k < N; k++) pin("reset_no_bytes", log_q[k].size(), 0);

        // Single register 5 = DEADBEEF, sink always ready.
        clear_logs();
        first_valid_cyc = -1;
        start_cyc = cyc + 1;
        pulse_start();
        wait_idle(2000, 1'b0);
        chk_dead_beef("deadbeef_ready");
        pin("first_valid_latency", first_valid_cyc - start_cyc, 2);
        pin("done_pulses_single", done_cnt[0], 1);

        // Same dump with a randomly stalling sink.
        clear_logs();
        pulse_start();
        wait_idle(5000, 1'b1);
        chk_dead_beef("deadbeef_stall");

        // Full dumps of 0x10000000+addr in both letter cases.
        for (int a = 0; a < 32; a++) mem[a] = 32'h1000_0000 + 32'(a);
        clear_logs();
        pulse_start();
        wait_idle(2000, 1'b0);
        chk_tail(1, "1000001F\n", "tail_upper");
        chk_tail(2, "1000001f\n", "tail_lower");
        pin("count_range2_9", log_q[3].size(), 72);

        // start during SEND and during DONE is ignored; after IDLE it dumps again.
        clear_logs();
        pulse_start();
        for (int i = 0; i < 3; i++) step();
        pulse_start();
        for (int i = 0; i < 200 && !(exp_q[0].size() == 1 && exp_q[0][0].kind == K_DONE); i++) step();
        pulse_start();
        for (int i = 0; i < 10 && exp_q[0].size() != 0; i++) step();
        pulse_start();
        wait_idle(2000, 1'b0);
        pin("done_pulses_inst0", done_cnt[0], 2);
        pin("bytes_inst0", log_q[0].size(), 18);
        pin("done_pulses_inst1", done_cnt[1], 1);
        pin("bytes_inst1", log_q[1].size(), 288);

        // Reset while the 4th nibble of register 3 is pending, then a fresh dump.
        for (int a = 0; a < 32; a++) mem[a] = $urandom;
        pulse_start();
        for (int i = 0; i < 1000 && !(exp_q[1].size() > 0 && exp_q[1][0].kind == K_BYTE &&
                                      exp_q[1][0].addr == 5'd3 && exp_q[1][0].nib == 4'd3); i++) step();
        pin("reached_reg3_nib3", int'(g_dut[1].u_if.regAddr), 3);
        tx_ready_s = 1'b0;
        rst_n = 1'b0;
        #1;
        all_rst_now();
        for (int k = 0; k < N; k++) exp_q[k].delete();
        step();
        step();
        rst_n = 1'b1;
        tx_ready_s = 1'b1;
        step();
        clear_logs();
        pulse_start();
        wait_idle(2000, 1'b0);
        pin("after_reset_bytes", log_q[1].size(), 288);
        pin("after_reset_done", done_cnt[1], 1);

        // Random start pulses and sink stalls over random register contents.
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < 32; a++) mem[a] = $urandom;
            for (int i = 0; i < 300; i++) begin
                start_s    = ($urandom_range(0, 19) == 0);
                tx_ready_s = ($urandom_range(0, 3) != 0);
                step();
            end
            start_s = 1'b0;
            wait_idle(4000, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
